// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one ALU between two requesters.
// Each accepted operation runs IDLE -> EXEC -> RESP. The ALU sees the operands
// captured at acceptance, its result is registered in EXEC, and the result is
// held in RESP until the consumer takes it.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid/ready/a/b/op       requester handshakes and operands (N = 0, 1)
//   alu_a, alu_b, alu_op, alu_oe  drive to the shared ALU
//   alu_y, alu_flags              ALU result {parity, overflow, gt, eq, lt}
//   rsp_valid/ready/id/y/flags    response handshake and payload
//   busy, op_count                status: not idle, completed operation count
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [1:0]  req1_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [1:0]  alu_op,
    output logic        alu_oe,
    input  logic [7:0]  alu_y,
    input  logic [4:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [7:0]  rsp_y,
    output logic [4:0]  rsp_flags,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   winner;
    logic   accept;

    // Round-robin winner: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Readys are gated by rst_n so both stay low while reset is held.
    assign accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;

    // State machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_op     <= 2'b00;
            alu_oe     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= 8'h00;
            rsp_flags  <= 5'b00000;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= winner ? req1_a  : req0_a;
                        alu_b      <= winner ? req1_b  : req0_b;
                        alu_op     <= winner ? req1_op : req0_op;
                        rsp_id     <= winner;
                        last_grant <= winner;
                        alu_oe     <= 1'b1;
                        busy       <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_flags <= alu_flags;
                    alu_oe    <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    alu_oe    <= 1'b0;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// operations compared against a transaction-level round-robin/ALU model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic [7:0]  alu_a, alu_b, alu_y;
    logic [1:0]  alu_op;
    logic        alu_oe;
    logic [4:0]  alu_flags;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_y;
    logic [4:0]  rsp_flags;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;

    // Model state: last granted requester and completed operations.
    logic        m_last;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    // ALU stub: sum and compare flags.
    assign alu_y     = alu_a + alu_b;
    assign alu_flags = {2'b00, alu_a > alu_b, alu_a == alu_b, alu_a < alu_b};

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_oe(alu_oe),
        .alu_y(alu_y), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags),
        .busy(busy), .op_count(op_count)
    );

    function automatic logic ref_winner(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

    function automatic logic [4:0] ref_flags(input logic [7:0] a, input logic [7:0] b);
        return {2'b00, a > b, a == b, a < b};
    endfunction

    // Advance to one time unit after the next falling edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Wait (bounded) for either ready; cyc==8 means none appeared.
    task automatic wait_grant(output logic who, output int cyc);
        cyc = 0;
        while (!(req0_ready || req1_ready) && cyc < 8) begin
            step();
            cyc++;
        end
        who = req1_ready;
    endtask

    // Wait (bounded) for rsp_valid; cyc counts falling edges waited.
    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 8) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        rst_n      = 1'b0;
        step();
        step();
        rst_n   = 1'b1;
        step();
        m_last  = 1'b1;
        m_count = 16'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        step();
        checks++;
        if ({req0_ready, req1_ready, alu_oe, rsp_valid, busy, rsp_id} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {req0_ready, req1_ready, alu_oe, rsp_valid, busy, rsp_id});
        end
        checks++;
        if ({alu_a, alu_b, alu_op, rsp_y, rsp_flags, op_count} !== 47'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0",
                     {alu_a, alu_b, alu_op, rsp_y, rsp_flags, op_count});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if ({busy, rsp_valid, alu_oe, req0_ready, req1_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b want 00000",
                     {busy, rsp_valid, alu_oe, req0_ready, req1_ready});
        end
        m_last  = 1'b1;
        m_count = 16'd0;
    endtask

    task automatic test_single();
        req0_a = 8'h12; req0_b = 8'h34; req0_op = 2'b00;
        req0_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        m_last = 1'b0;
        checks++;
        if ({alu_oe, busy, rsp_valid, alu_a, alu_b, alu_op} !== {3'b110, 8'h12, 8'h34, 2'b00}) begin
            errors++;
            $display("FAIL single_exec: got %h want %h",
                     {alu_oe, busy, rsp_valid, alu_a, alu_b, alu_op}, {3'b110, 8'h12, 8'h34, 2'b00});
        end
        step();
        checks++;
        if ({rsp_valid, alu_oe, rsp_id, rsp_y, rsp_flags} !== {3'b100, 8'h46, 5'b00001}) begin
            errors++;
            $display("FAIL single_rsp: got %h want %h",
                     {rsp_valid, alu_oe, rsp_id, rsp_y, rsp_flags}, {3'b100, 8'h46, 5'b00001});
        end
        step();
        m_count = m_count + 16'd1;
        checks++;
        if ({rsp_valid, busy, op_count} !== {2'b00, m_count}) begin
            errors++;
            $display("FAIL single_done: got %h want %h", {rsp_valid, busy, op_count}, {2'b00, m_count});
        end
    endtask

    task automatic test_fairness();
        logic       who;
        int         cyc;
        logic       order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] exp_y;
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_a = 8'(i);          req0_b = 8'h01;
            req1_a = 8'(8'h80 + i);  req1_b = 8'h01;
            exp_y  = order[i] ? 8'(req1_a + 8'h01) : 8'(req0_a + 8'h01);
            #1;
            wait_grant(who, cyc);
            checks++;
            if (cyc >= 8 || who !== order[i]) begin
                errors++;
                $display("FAIL fair_grant%0d: got id %0d after %0d cycles want id %0d", i, who, cyc, order[i]);
            end
            m_last = order[i];
            step();
            wait_rsp(cyc);
            checks++;
            if (cyc != 1 || rsp_id !== order[i] || rsp_y !== exp_y) begin
                errors++;
                $display("FAIL fair_rsp%0d: got id %0d y %h lat %0d want id %0d y %h lat 1",
                         i, rsp_id, rsp_y, cyc, order[i], exp_y);
            end
            step();
            m_count = m_count + 16'd1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (op_count !== 16'd4) begin
            errors++;
            $display("FAIL fair_count: got %0d want 4", op_count);
        end
    endtask

    task automatic test_backpressure();
        logic who;
        int   cyc;
        req0_a = 8'h55; req0_b = 8'h55; req0_op = 2'b01;
        req1_a = 8'h03; req1_b = 8'h04; req1_op = 2'b10;
        req0_valid = 1'b1;
        rsp_ready  = 1'b0;
        #1;
        wait_grant(who, cyc);
        checks++;
        if (cyc >= 8 || who !== 1'b0) begin
            errors++;
            $display("FAIL bp_grant: got id %0d after %0d cycles want id 0", who, cyc);
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL bp_exec_ready: got %b want 00", {req0_ready, req1_ready});
        end
        step();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({rsp_valid, req0_ready, req1_ready, rsp_y, rsp_flags, op_count} !==
                {3'b100, 8'hAA, 5'b00010, m_count}) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h want %h", k,
                         {rsp_valid, req0_ready, req1_ready, rsp_y, rsp_flags, op_count},
                         {3'b100, 8'hAA, 5'b00010, m_count});
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        m_count = m_count + 16'd1;
        checks++;
        if ({rsp_valid, op_count, req1_ready} !== {1'b0, m_count, 1'b1}) begin
            errors++;
            $display("FAIL bp_done: got %h want %h", {rsp_valid, op_count, req1_ready},
                     {1'b0, m_count, 1'b1});
        end
        step();
        req1_valid = 1'b0;
        wait_rsp(cyc);
        checks++;
        if (cyc != 1 || rsp_id !== 1'b1 || rsp_y !== 8'h07) begin
            errors++;
            $display("FAIL bp_pending_rsp: got id %0d y %h lat %0d want id 1 y 07 lat 1", rsp_id, rsp_y, cyc);
        end
        step();
        m_last  = 1'b1;
        m_count = m_count + 16'd1;
    endtask

    task automatic test_operand_change();
        logic who;
        int   cyc;
        req1_a = 8'h01; req1_b = 8'h02; req1_op = 2'b11;
        req1_valid = 1'b1;
        #1;
        wait_grant(who, cyc);
        checks++;
        if (cyc >= 8 || who !== 1'b1) begin
            errors++;
            $display("FAIL opchg_grant: got id %0d after %0d cycles want id 1", who, cyc);
        end
        step();
        req1_a = 8'hFF; req1_b = 8'hFF; req1_op = 2'b00;
        req1_valid = 1'b0;
        #1;
        checks++;
        if ({alu_a, alu_op} !== {8'h01, 2'b11}) begin
            errors++;
            $display("FAIL opchg_alu: got %h want %h", {alu_a, alu_op}, {8'h01, 2'b11});
        end
        wait_rsp(cyc);
        checks++;
        if (cyc != 1 || rsp_id !== 1'b1 || rsp_y !== 8'h03) begin
            errors++;
            $display("FAIL opchg_rsp: got id %0d y %h lat %0d want id 1 y 03 lat 1", rsp_id, rsp_y, cyc);
        end
        step();
        m_last  = 1'b1;
        m_count = m_count + 16'd1;
    endtask

    task automatic test_reset_mid_exec();
        logic who;
        int   cyc;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        wait_grant(who, cyc);
        step();
        checks++;
        if (alu_oe !== 1'b1) begin
            errors++;
            $display("FAIL rst_exec_entry: got alu_oe %b want 1", alu_oe);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, alu_oe, rsp_valid, busy, rsp_id,
             alu_a, alu_b, alu_op, rsp_y, rsp_flags, op_count} !== 53'd0) begin
            errors++;
            $display("FAIL rst_async: got %h want 0", {req0_ready, req1_ready, alu_oe, rsp_valid,
                     busy, rsp_id, alu_a, alu_b, alu_op, rsp_y, rsp_flags, op_count});
        end
        step();
        step();
        rst_n = 1'b1;
        m_last  = 1'b1;
        m_count = 16'd0;
        #1;
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
            errors++;
            $display("FAIL rst_tie: got %b want 010", {rsp_valid, req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        m_last = 1'b0;
        wait_rsp(cyc);
        step();
        m_count = m_count + 16'd1;
        checks++;
        if (op_count !== m_count) begin
            errors++;
            $display("FAIL rst_count: got %0d want %0d", op_count, m_count);
        end
    endtask

    task automatic test_random();
        logic       who, exp_w;
        int         cyc, stall;
        logic [1:0] v, eop;
        logic [7:0] ea, eb, ey;
        logic [4:0] ef;
        for (int n = 0; n < 40; n++) begin
            v = 2'($urandom_range(1, 3));
            req0_valid = v[0];
            req1_valid = v[1];
            req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 2'($urandom);
            req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 2'($urandom);
            if (n % 5 == 0) req1_b = req1_a;
            stall = $urandom_range(0, 3);
            rsp_ready = (stall == 0);
            exp_w = ref_winner(v[0], v[1], m_last);
            ea  = exp_w ? req1_a  : req0_a;
            eb  = exp_w ? req1_b  : req0_b;
            eop = exp_w ? req1_op : req0_op;
            ey  = 8'(ea + eb);
            ef  = ref_flags(ea, eb);
            #1;
            wait_grant(who, cyc);
            checks++;
            if (cyc != 0 || who !== exp_w) begin
                errors++;
                $display("FAIL rand_grant%0d: got id %0d after %0d cycles want id %0d at once", n, who, cyc, exp_w);
            end
            m_last = exp_w;
            step();
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_a = ~req0_a; req1_a = ~req1_a; req0_b = 8'($urandom); req1_b = 8'($urandom);
            #1;
            checks++;
            if ({alu_oe, req0_ready, req1_ready, alu_a, alu_b, alu_op} !== {3'b100, ea, eb, eop}) begin
                errors++;
                $display("FAIL rand_exec%0d: got %h want %h", n,
                         {alu_oe, req0_ready, req1_ready, alu_a, alu_b, alu_op}, {3'b100, ea, eb, eop});
            end
            wait_rsp(cyc);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            checks++;
            if (cyc != 1 || {rsp_id, rsp_y, rsp_flags} !== {exp_w, ey, ef}) begin
                errors++;
                $display("FAIL rand_rsp%0d: got %h lat %0d want %h lat 1", n,
                         {rsp_id, rsp_y, rsp_flags}, cyc, {exp_w, ey, ef});
            end
            for (int s = 0; s < stall; s++) begin
                step();
                checks++;
                if ({rsp_valid, rsp_id, rsp_y, rsp_flags} !== {1'b1, exp_w, ey, ef}) begin
                    errors++;
                    $display("FAIL rand_stall%0d: got %h want %h", n,
                             {rsp_valid, rsp_id, rsp_y, rsp_flags}, {1'b1, exp_w, ey, ef});
                end
            end
            rsp_ready = 1'b1;
            step();
            m_count = m_count + 16'd1;
            checks++;
            if ({rsp_valid, busy, op_count} !== {2'b00, m_count}) begin
                errors++;
                $display("FAIL rand_done%0d: got %h want %h", n, {rsp_valid, busy, op_count}, {2'b00, m_count});
            end
        end
    endtask

    task automatic test_wrap();
        logic who;
        int   cyc;
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        m_count = 16'hFFFF;
        req0_a = 8'h01; req0_b = 8'h01;
        req0_valid = 1'b1;
        rsp_ready  = 1'b1;
        #1;
        checks++;
        if (op_count !== m_count) begin
            errors++;
            $display("FAIL wrap_preload: got %h want %h", op_count, m_count);
        end
        wait_grant(who, cyc);
        step();
        req0_valid = 1'b0;
        wait_rsp(cyc);
        step();
        m_count = m_count + 16'd1;
        checks++;
        if (op_count !== m_count || m_count !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_count: got %h want 0000", op_count);
        end
    endtask

    initial begin
        m_last  = 1'b1;
        m_count = 16'd0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_operand_change();
        test_reset_mid_exec();
        test_random();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-005 req0_ready, req1_ready  output  1 each  requester N's operation is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  8 each  operands.
REQ-007 req0_op, req1_op  input  2 each  ALU opcode, passed through unmodified.
REQ-008 alu_a, alu_b  output  8 each  operands driven to the shared ALU.
REQ-009 alu_op  output  2  opcode to the ALU.
REQ-010 alu_oe  output  1  ALU output enable.
REQ-011 alu_y  input  8  ALU result.
REQ-012 alu_flags  input  5  {parity, overflow, greater, is_eq, less}, MSB first.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumer accepts.
REQ-015 rsp_id  output  1  requester the response belongs to.
REQ-016 rsp_y  output  8  registered result.
REQ-017 rsp_flags  output  5  registered flags.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 op_count  output  16  operations completed since reset.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-021 In IDLE, the block SHALL grant at most one requester using round-robin on a 1-bit last_grant pointer.
- Only one valid: that requester wins.
- Both valid: the requester other than last_grant wins.
REQ-022 reqN_ready SHALL be high only in IDLE, only for the winner, and SHALL be combinational from valid and state.
REQ-023 On acceptance (valid and ready):
- operands, opcode and id SHALL be captured into registers;
- last_grant SHALL be set to the winner;
- the state SHALL go to EXEC.
REQ-024 In EXEC:
- alu_a, alu_b and alu_op SHALL present the captured values, and alu_oe SHALL be 1;
- at the closing edge, alu_y and alu_flags SHALL be registered into rsp_y and rsp_flags;
- the state SHALL go to RESP.
REQ-025 Outside EXEC, alu_oe SHALL be 0 and alu_a, alu_b and alu_op SHALL hold their last captured values.
REQ-026 In RESP, rsp_valid SHALL be 1; rsp_id, rsp_y and rsp_flags SHALL hold stable until rsp_ready is sampled high.
REQ-027 When rsp_ready is high in RESP:
- the state SHALL return to IDLE;
- op_count SHALL increment by 1, wrapping from 0xFFFF to 0x0000.
REQ-028 Latency SHALL be as follows: with acceptance at edge N, rsp_valid SHALL be high in the cycle after edge N+1; the minimum issue interval is 3 cycles.
REQ-029 The block SHALL never accept a new request in EXEC or RESP; requester valids seen in those states SHALL have no effect and SHALL NOT be lost (handshake holds).
REQ-030 A requester deasserting valid before ready SHALL NOT be granted and SHALL NOT move last_grant.
REQ-031 Requester inputs SHALL be sampled only at the acceptance edge; later changes SHALL NOT affect the in-flight operation.

Reset
REQ-032 While rst_n is low, the block SHALL hold the following outputs, and on rst_n rise SHALL remain in IDLE:
- state IDLE, last_grant 1 (so requester 0 wins the first tie);
- alu_a, alu_b = 0x00, alu_op = 00, alu_oe 0;
- rsp_valid 0, rsp_id 0, rsp_y 0x00, rsp_flags 0, busy 0, op_count 0, both readys 0.
REQ-033 Reset asserted in EXEC or RESP SHALL abort the operation immediately, SHALL produce no response, and SHALL NOT increment op_count.

Verification
The bench ALU stub SHALL return alu_y = alu_a + alu_b (mod 256) and alu_flags = {0,0,a>b,a==b,a<b}.
REQ-034 Single request: req0 a=0x12, b=0x34, op=00, rsp_ready=1 -> req0_ready at cycle 0, alu_oe=1 at cycle 1, then rsp_valid=1 with rsp_id=0, rsp_y=0x46, rsp_flags=5'b00001 at cycle 2; op_count becomes 1.
REQ-035 Tie, then fairness: both valid continuously for 4 operations -> grant order 0,1,0,1; op_count=4.
REQ-036 Backpressure: rsp_ready held 0 for 5 cycles in RESP with a=b=0x55 -> rsp_valid held, rsp_y=0xAA and rsp_flags=5'b00010 stable; no ready to either requester; completion on the cycle rsp_ready=1.
REQ-037 Operand change after acceptance: req1 a changes 0x01->0xFF during EXEC -> rsp_y uses 0x01.
REQ-038 Reset mid-EXEC: rst_n pulsed low in EXEC -> all outputs at reset values asynchronously; no rsp_valid; next tie grants requester 0.
REQ-039 Counter wrap: op_count preloaded via 65536 completed operations (or forced) -> reads 0x0000 after the wrap.
